// File: rtl/mips_axi_pkg.sv
// ============================================================================
// Package : mips_axi_pkg
// Shared AXI4 encodings and the instruction-bridge FSM state type.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_axi_pkg;

  // AXI4 AxSIZE / AxBURST encodings used by the single-word read bridge
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // AXI4 RRESP / BRESP encodings
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Read-bridge FSM: one outstanding AR at a time
  typedef enum logic [1:0] {
    BR_IDLE = 2'd0,
    BR_ADDR = 2'd1,
    BR_DATA = 2'd2
  } bridge_state_e;

  // SLVERR and DECERR both carry bit 1 set
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/i_axi_read_bridge.sv
// ============================================================================
// Module  : i_axi_read_bridge
// Instruction-cache miss port to AXI4 read bridge. Converts a level-held
// single-word request into one AR/R transaction and returns the word as a
// one-cycle m_ready pulse. Responses whose request was dropped or redirected
// while in flight are drained and not forwarded.
// Optional macro: INST_BRIDGE_ERR_EN adds the bus_err output and zeroes
// m_dout on a SLVERR/DECERR response.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module i_axi_read_bridge
  import mips_axi_pkg::*;
#(
  parameter int A_WIDTH = 32,
  parameter int ID_W    = 4,
  parameter int AXI_ID  = 0
) (
  input  logic               clk,
  input  logic               clrn,
  // instruction cache side
  input  logic [A_WIDTH:0]   m_a,
  input  logic               m_strobe,
  output logic [31:0]        m_dout,
  output logic               m_ready,
`ifdef INST_BRIDGE_ERR_EN
  output logic               bus_err,
`endif
  // AXI4 read address channel
  output logic [ID_W-1:0]    arid,
  output logic [A_WIDTH-1:0] araddr,
  output logic [7:0]         arlen,
  output logic [2:0]         arsize,
  output logic [1:0]         arburst,
  output logic               arvalid,
  input  logic               arready,
  // AXI4 read data channel
  input  logic [ID_W-1:0]    rid,
  input  logic [31:0]        rdata,
  input  logic [1:0]         rresp,
  input  logic               rlast,
  input  logic               rvalid,
  output logic               rready
);

  bridge_state_e      state_q, state_d;
  logic [A_WIDTH-1:0] araddr_q, araddr_d;
  logic               arvalid_q, arvalid_d;
  logic               rready_q, rready_d;
  logic               m_ready_q, m_ready_d;
  logic [31:0]        m_dout_q, m_dout_d;
  logic               req_match;
  logic               unused_bits;

  // The in-flight response belongs to the cache only if it is still asking for that word
  assign req_match = m_strobe && (m_a[A_WIDTH-1:2] == araddr_q[A_WIDTH-1:2]);

  // Fixed single-beat word read
  assign arid    = ID_W'(AXI_ID);
  assign arlen   = 8'd0;
  assign arsize  = AXI_SIZE_WORD;
  assign arburst = AXI_BURST_INCR;

  assign araddr  = araddr_q;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign m_ready = m_ready_q;
  assign m_dout  = m_dout_q;

`ifdef INST_BRIDGE_ERR_EN
  logic bus_err_q, bus_err_d;
  assign bus_err     = bus_err_q;
  assign unused_bits = ^{m_a[A_WIDTH], m_a[1:0], rid, rresp[0]};
`else
  assign unused_bits = ^{m_a[A_WIDTH], m_a[1:0], rid, rresp};
`endif

  // Next-state and registered-output logic for the IDLE -> ADDR -> DATA sequence
  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    m_ready_d = 1'b0;
    m_dout_d  = m_dout_q;
`ifdef INST_BRIDGE_ERR_EN
    bus_err_d = 1'b0;
`endif
    case (state_q)
      BR_IDLE: begin
        // m_ready high means the strobe still refers to the word just delivered
        if (m_strobe && !m_ready_q) begin
          araddr_d  = {m_a[A_WIDTH-1:2], 2'b00};
          arvalid_d = 1'b1;
          state_d   = BR_ADDR;
        end
      end
      BR_ADDR: begin
        // AR must stay asserted and stable until accepted, even if the cache gave up
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = BR_DATA;
        end
      end
      BR_DATA: begin
        // A beat without rlast is accepted and dropped; only the last beat completes
        if (rvalid && rready_q && rlast) begin
          rready_d = 1'b0;
          state_d  = BR_IDLE;
          if (req_match) begin
            m_ready_d = 1'b1;
`ifdef INST_BRIDGE_ERR_EN
            if (resp_is_err(rresp)) begin
              m_dout_d  = 32'h0;
              bus_err_d = 1'b1;
            end else begin
              m_dout_d  = rdata;
            end
`else
            m_dout_d = rdata;
`endif
          end
        end
      end
      default: begin
        state_d   = BR_IDLE;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in progress
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= BR_IDLE;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      m_ready_q <= 1'b0;
      m_dout_q  <= 32'h0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      m_ready_q <= m_ready_d;
      m_dout_q  <= m_dout_d;
    end
  end

`ifdef INST_BRIDGE_ERR_EN
  // Error flag accompanies the m_ready pulse
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= bus_err_d;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_i_axi_read_bridge.sv
// ============================================================================
// Module  : tb_i_axi_read_bridge
// Self-checking bench for i_axi_read_bridge: behavioural AXI slave with
// configurable AR latency, error and stray-beat injection, and a scoreboard
// of expected returned words.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i_axi_read_bridge;

  localparam int A_WIDTH = 32;
  localparam int ID_W    = 4;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic               clk;
  logic               clrn;
  logic [A_WIDTH:0]   m_a;
  logic               m_strobe;
  logic [31:0]        m_dout;
  logic               m_ready;
  logic               bus_err;
  logic [ID_W-1:0]    arid;
  logic [A_WIDTH-1:0] araddr;
  logic [7:0]         arlen;
  logic [2:0]         arsize;
  logic [1:0]         arburst;
  logic               arvalid;
  logic               arready;
  logic [ID_W-1:0]    rid;
  logic [31:0]        rdata;
  logic [1:0]         rresp;
  logic               rlast;
  logic               rvalid;
  logic               rready;

  // slave control and observation
  int          ar_delay;
  logic [1:0]  err_resp;
  logic        extra_beat;
  int          ar_cnt;
  int          r_phase;
  int          ar_count;
  logic [31:0] last_ar_addr;

  // scoreboard
  exp_t exp_q[$];
  int   nvec;
  int   nfail;
  int   ready_pulses;
  logic prev_ready;

  i_axi_read_bridge #(.A_WIDTH(A_WIDTH), .ID_W(ID_W), .AXI_ID(0)) dut (
    .clk(clk), .clrn(clrn),
    .m_a(m_a), .m_strobe(m_strobe), .m_dout(m_dout), .m_ready(m_ready),
`ifdef INST_BRIDGE_ERR_EN
    .bus_err(bus_err),
`endif
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

`ifndef INST_BRIDGE_ERR_EN
  assign bus_err = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents seen by the slave
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0F0F_3C3C;
  endfunction

  // Behavioural AXI slave, driven on the falling edge
  always @(negedge clk) begin
    arready = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    rid     = '0;
    if (!clrn) begin
      ar_cnt  = 0;
      r_phase = 0;
    end else if (r_phase == 2) begin
      rvalid  = 1'b1;
      rlast   = 1'b0;
      rdata   = 32'hDEAD_BEEF;
      rresp   = 2'b00;
      r_phase = 1;
    end else if (r_phase == 1) begin
      rvalid  = 1'b1;
      rlast   = 1'b1;
      rdata   = mem_word(last_ar_addr);
      rresp   = err_resp;
      r_phase = 0;
    end else if (arvalid) begin
      if (ar_cnt >= ar_delay) begin
        arready      = 1'b1;
        last_ar_addr = araddr;
        ar_count     = ar_count + 1;
        ar_cnt       = 0;
        r_phase      = extra_beat ? 2 : 1;
      end else begin
        ar_cnt = ar_cnt + 1;
      end
    end
  end

  // Scoreboard: every m_ready pulse must match the oldest expected word
  always @(negedge clk) begin
    if (!clrn) begin
      prev_ready = 1'b0;
    end else begin
      if (m_ready) begin
        exp_t e;
        ready_pulses = ready_pulses + 1;
        nvec = nvec + 1;
        if (prev_ready !== 1'b0) begin
          nfail = nfail + 1;
          $display("FAIL m_ready_width: m_ready high two cycles in a row, required one-cycle pulse");
        end
        if (exp_q.size() == 0) begin
          nfail = nfail + 1;
          $display("FAIL unexpected_m_ready: m_dout=%h with no outstanding expected word", m_dout);
        end else begin
          e = exp_q.pop_front();
          if (m_dout !== e.data || bus_err !== e.err) begin
            nfail = nfail + 1;
            $display("FAIL m_dout: got data=%h bus_err=%b, required data=%h bus_err=%b",
                     m_dout, bus_err, e.data, e.err);
          end
        end
      end
      prev_ready = m_ready;
    end
  end

  task automatic wait_ready(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (m_ready === 1'b1) seen = 1;
    end
    if (!seen) begin
      nvec  = nvec + 1;
      nfail = nfail + 1;
      $display("FAIL wait_ready: no m_ready within %0d cycles, required a pulse", budget);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    nvec = nvec + 10;
    if (arvalid !== 1'b0) begin nfail++; $display("FAIL rst_arvalid: got %b required 0", arvalid); end
    if (rready !== 1'b0) begin nfail++; $display("FAIL rst_rready: got %b required 0", rready); end
    if (m_ready !== 1'b0) begin nfail++; $display("FAIL rst_m_ready: got %b required 0", m_ready); end
    if (m_dout !== 32'h0) begin nfail++; $display("FAIL rst_m_dout: got %h required 0", m_dout); end
    if (araddr !== 32'h0) begin nfail++; $display("FAIL rst_araddr: got %h required 0", araddr); end
    if (bus_err !== 1'b0) begin nfail++; $display("FAIL rst_bus_err: got %b required 0", bus_err); end
    if (arlen !== 8'd0) begin nfail++; $display("FAIL arlen: got %h required 0", arlen); end
    if (arsize !== 3'b010) begin nfail++; $display("FAIL arsize: got %b required 010", arsize); end
    if (arburst !== 2'b01) begin nfail++; $display("FAIL arburst: got %b required 01", arburst); end
    if (arid !== 4'd0) begin nfail++; $display("FAIL arid: got %h required 0", arid); end
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
  endtask

  // Zero-wait slave: arvalid in cycle 1, m_ready in cycle 3
  task automatic test_zero_wait();
    m_a      = {1'b1, 32'hBFC0_0004};
    m_strobe = 1'b1;
    exp_q.push_back('{data: mem_word(32'hBFC0_0004), err: 1'b0});
    @(negedge clk);
    nvec = nvec + 2;
    if (arvalid !== 1'b1) begin nfail++; $display("FAIL zw_arvalid_c1: got %b required 1", arvalid); end
    if (araddr !== 32'hBFC0_0004) begin nfail++; $display("FAIL zw_araddr_c1: got %h required bfc00004", araddr); end
    @(negedge clk);
    nvec = nvec + 2;
    if (rready !== 1'b1 || arvalid !== 1'b0) begin
      nfail++; $display("FAIL zw_c2: got rready=%b arvalid=%b required 1/0", rready, arvalid);
    end
    if (m_ready !== 1'b0) begin nfail++; $display("FAIL zw_early_ready_c2: got %b required 0", m_ready); end
    @(negedge clk);
    nvec = nvec + 1;
    if (m_ready !== 1'b1) begin nfail++; $display("FAIL zw_ready_c3: got %b required 1", m_ready); end
    m_strobe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Slow arready, request dropped: AR stays stable, response drained silently
  task automatic test_ar_stall_drop();
    int pulses0, ars0;
    pulses0  = ready_pulses;
    ars0     = ar_count;
    ar_delay = 5;
    m_a      = {1'b0, 32'h0000_1000};
    m_strobe = 1'b1;
    @(negedge clk);
    for (int c = 2; c <= 6; c++) begin
      @(negedge clk);
      if (c == 2) m_strobe = 1'b0;
      nvec = nvec + 1;
      if (arvalid !== 1'b1 || araddr !== 32'h0000_1000) begin
        nfail++;
        $display("FAIL stall_ar_stable c%0d: got arvalid=%b araddr=%h required 1/00001000", c, arvalid, araddr);
      end
    end
    repeat (5) @(negedge clk);
    nvec = nvec + 3;
    if (ready_pulses !== pulses0) begin nfail++; $display("FAIL stall_drained: got %0d pulses required 0", ready_pulses - pulses0); end
    if (ar_count !== ars0 + 1) begin nfail++; $display("FAIL stall_ar_count: got %0d required 1", ar_count - ars0); end
    if (rready !== 1'b0 || arvalid !== 1'b0) begin
      nfail++; $display("FAIL stall_idle: got rready=%b arvalid=%b required 0/0", rready, arvalid);
    end
    ar_delay = 0;
  endtask

  // Address redirected while in DATA: old word discarded, new AR launched
  task automatic test_redirect();
    int pulses0, ars0;
    pulses0  = ready_pulses;
    ars0     = ar_count;
    m_a      = {1'b0, 32'h0000_0100};
    m_strobe = 1'b1;
    @(negedge clk);
    @(negedge clk);
    m_a = {1'b0, 32'h0000_0200};
    exp_q.push_back('{data: mem_word(32'h0000_0200), err: 1'b0});
    wait_ready(12);
    m_strobe = 1'b0;
    repeat (3) @(negedge clk);
    nvec = nvec + 3;
    if (last_ar_addr !== 32'h0000_0200) begin nfail++; $display("FAIL redir_araddr: got %h required 00000200", last_ar_addr); end
    if (ar_count !== ars0 + 2) begin nfail++; $display("FAIL redir_ar_count: got %0d required 2", ar_count - ars0); end
    if (ready_pulses !== pulses0 + 1) begin nfail++; $display("FAIL redir_pulses: got %0d required 1", ready_pulses - pulses0); end
  endtask

  // Strobe held through the m_ready cycle, then a new miss right after
  task automatic test_back_to_back();
    int ars0;
    ars0     = ar_count;
    m_a      = {1'b0, 32'h0000_2000};
    m_strobe = 1'b1;
    exp_q.push_back('{data: mem_word(32'h0000_2000), err: 1'b0});
    wait_ready(8);
    @(negedge clk);
    nvec = nvec + 1;
    if (arvalid !== 1'b0) begin nfail++; $display("FAIL b2b_no_dup: got arvalid=%b required 0", arvalid); end
    m_a = {1'b1, 32'h0000_3003};
    exp_q.push_back('{data: mem_word(32'h0000_3000), err: 1'b0});
    @(negedge clk);
    nvec = nvec + 1;
    if (arvalid !== 1'b1 || araddr !== 32'h0000_3000) begin
      nfail++; $display("FAIL b2b_second_ar: got arvalid=%b araddr=%h required 1/00003000", arvalid, araddr);
    end
    wait_ready(8);
    m_strobe = 1'b0;
    repeat (4) @(negedge clk);
    nvec = nvec + 1;
    if (ar_count !== ars0 + 2) begin nfail++; $display("FAIL b2b_ar_count: got %0d required 2", ar_count - ars0); end
  endtask

  // A stray beat without rlast precedes the real one
  task automatic test_no_rlast();
    extra_beat = 1'b1;
    m_a        = {1'b0, 32'h0000_4000};
    m_strobe   = 1'b1;
    exp_q.push_back('{data: mem_word(32'h0000_4000), err: 1'b0});
    wait_ready(10);
    m_strobe   = 1'b0;
    extra_beat = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // SLVERR response on a matched request
  task automatic test_error_resp();
    err_resp = 2'b10;
    m_a      = {1'b0, 32'h0000_5000};
    m_strobe = 1'b1;
`ifdef INST_BRIDGE_ERR_EN
    exp_q.push_back('{data: 32'h0, err: 1'b1});
`else
    exp_q.push_back('{data: mem_word(32'h0000_5000), err: 1'b0});
`endif
    wait_ready(8);
    m_strobe = 1'b0;
    @(negedge clk);
    nvec = nvec + 1;
    if (bus_err !== 1'b0 || m_ready !== 1'b0) begin
      nfail++; $display("FAIL err_one_cycle: got bus_err=%b m_ready=%b required 0/0", bus_err, m_ready);
    end
    err_resp = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  // Reset asserted while waiting in ADDR, then a clean transaction
  task automatic test_reset_mid();
    int ars0;
    ars0     = ar_count;
    ar_delay = 10;
    m_a      = {1'b0, 32'h0000_6000};
    m_strobe = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 clrn = 1'b0;
    #1;
    nvec = nvec + 3;
    if (arvalid !== 1'b0 || rready !== 1'b0 || m_ready !== 1'b0) begin
      nfail++; $display("FAIL mid_rst_ctrl: got arvalid=%b rready=%b m_ready=%b required 0", arvalid, rready, m_ready);
    end
    if (araddr !== 32'h0) begin nfail++; $display("FAIL mid_rst_araddr: got %h required 0", araddr); end
    if (m_dout !== 32'h0) begin nfail++; $display("FAIL mid_rst_m_dout: got %h required 0", m_dout); end
    m_strobe = 1'b0;
    repeat (2) @(negedge clk);
    clrn     = 1'b1;
    ar_delay = 0;
    @(negedge clk);
    m_a      = {1'b0, 32'h0000_7000};
    m_strobe = 1'b1;
    exp_q.push_back('{data: mem_word(32'h0000_7000), err: 1'b0});
    @(negedge clk);
    nvec = nvec + 1;
    if (arvalid !== 1'b1 || araddr !== 32'h0000_7000) begin
      nfail++; $display("FAIL post_rst_ar: got arvalid=%b araddr=%h required 1/00007000", arvalid, araddr);
    end
    wait_ready(8);
    m_strobe = 1'b0;
    repeat (3) @(negedge clk);
    nvec = nvec + 1;
    if (ar_count !== ars0 + 1) begin nfail++; $display("FAIL post_rst_ar_count: got %0d required 1", ar_count - ars0); end
  endtask

  initial begin
    nvec = 0; nfail = 0; ready_pulses = 0; prev_ready = 1'b0;
    ar_delay = 0; err_resp = 2'b00; extra_beat = 1'b0;
    ar_cnt = 0; r_phase = 0; ar_count = 0; last_ar_addr = '0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rid = '0; rdata = '0; rresp = 2'b00;
    m_a = '0; m_strobe = 1'b0;
    clrn = 1'b1;
    #2 clrn = 1'b0;

    test_reset();
    test_zero_wait();
    test_ar_stall_drop();
    test_redirect();
    test_back_to_back();
    test_no_rlast();
    test_error_resp();
    test_reset_mid();

    nvec = nvec + 1;
    if (exp_q.size() != 0) begin
      nfail++; $display("FAIL scoreboard_leftover: got %0d unreturned words required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

`default_nettype wire
